// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_responder_if
// Load/store handshake bundle between the memory-access stage (master) and
// the data-memory responder (slave).
//   req    master->slave  request valid
//   we     master->slave  1 = store, 0 = load
//   addr   master->slave  byte address
//   wdata  master->slave  store data
//   be     master->slave  byte enables, be[i] covers wdata[8i+7:8i]
//   ready  slave->master  responder can accept a request this cycle
//   ack    slave->master  one-cycle response strobe
//   rdata  slave->master  load data / pre-store word, valid with ack
//   err    slave->master  error flag, valid with ack
// ----------------------------------------------------------------------------
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, ack, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, ack, rdata, err
    );
endinterface

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Word-organised data memory that answers load/store requests over a
// req/ready/ack handshake, with a programmable number of wait states so the
// initiator's stall logic sees a multi-cycle memory.
//
// Ports:
//   CLK  clock, rising edge
//   RST  asynchronous, active-high reset
//   bus  dmem_responder_if.slave (req, we, addr, wdata, be / ready, ack,
//        rdata, err)
//
// Parameters:
//   DMEM_SIZE    number of 32-bit words (word index = addr>>2)
//   WAIT_CYCLES  wait states between accept and response (0..15)
//
// Optional feature macro DMEM_ERR_EN: when defined, misaligned or
// out-of-range addresses are flagged with err=1, return rdata=0 and never
// write. When undefined, err is tied low, addr[1:0] is ignored and the word
// index wraps modulo DMEM_SIZE.
//
// States:
//   S_IDLE | ready=1, accept request and latch it
//   S_WAIT | wait states, counter runs down to 1
//   S_RESP | ack=1 for one cycle, rdata/err valid
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DMEM_SIZE   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    dmem_responder_if.slave   bus
);
    localparam int IDX_W = $clog2(DMEM_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;

    logic [31:0] addr_q, wdata_q;
    logic        we_q;
    logic [3:0]  be_q;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DMEM_SIZE];

    logic [31:0] eff_addr, eff_wdata;
    logic        eff_we;
    logic [3:0]  eff_be;
    logic [IDX_W-1:0] idx;
    logic        req_err;
    logic        commit;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (bus.req) begin
                    cnt_next   = 4'(WAIT_CYCLES);
                    state_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) state_next = S_RESP;
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // With zero wait states the response is taken on the accept edge itself,
    // before the latch registers hold the request, so use the live bus there.
    assign eff_addr  = (state == S_IDLE) ? bus.addr  : addr_q;
    assign eff_wdata = (state == S_IDLE) ? bus.wdata : wdata_q;
    assign eff_we    = (state == S_IDLE) ? bus.we    : we_q;
    assign eff_be    = (state == S_IDLE) ? bus.be    : be_q;

    assign idx    = eff_addr[IDX_W+1:2];
    // RESP always falls back to IDLE, so any transition into RESP is an entry.
    assign commit = !RST && (state_next == S_RESP);

`ifdef DMEM_ERR_EN
    assign req_err = (eff_addr[1:0] != 2'b00) ||
                     ({2'b00, eff_addr[31:2]} >= 32'(DMEM_SIZE));
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{eff_addr[1:0], eff_addr[31:IDX_W+2]};
    assign req_err = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == S_IDLE && bus.req) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                we_q    <= bus.we;
                be_q    <= bus.be;
            end
            if (commit) begin
                // Stores also return the word as it was before the write.
                rdata_q <= req_err ? 32'd0 : mem[idx];
                err_q   <= req_err;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (commit && eff_we && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (eff_be[i]) mem[idx][8*i +: 8] <= eff_wdata[8*i +: 8];
            end
        end
    end

    assign bus.ready = (state == S_IDLE) && !RST;
    assign bus.ack   = (state == S_RESP);
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
// Directed self-checking bench for dmem_responder. One instance runs with
// WAIT_CYCLES=2 for the main sequence, a second with WAIT_CYCLES=0 for the
// back-to-back throughput case. Both share CLK and RST.
// ----------------------------------------------------------------------------
module tb_dmem_responder;
    logic CLK;
    logic RST;

    dmem_responder_if bus2 ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DMEM_SIZE(1024), .WAIT_CYCLES(2)) u_dut2 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus2.slave)
    );

    dmem_responder #(.DMEM_SIZE(1024), .WAIT_CYCLES(0)) u_dut0 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus0.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full transaction on the WAIT_CYCLES=2 instance, checking handshake timing.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b, output logic [31:0] rd, output logic e);
        int lat;
        int low;
        @(negedge CLK);
        bus2.req   = 1'b1;
        bus2.we    = w;
        bus2.addr  = a;
        bus2.wdata = wd;
        bus2.be    = b;
        chk("ready_before_accept", 32'(bus2.ready), 32'd1);
        @(negedge CLK);
        bus2.req = 1'b0;
        lat = 1;
        low = 0;
        while (bus2.ack !== 1'b1 && lat < 20) begin
            if (bus2.ready === 1'b0) low++;
            @(negedge CLK);
            lat++;
        end
        if (bus2.ready === 1'b0) low++;
        chk("ack_latency", 32'(lat), 32'd3);
        chk("ready_low_cycles", 32'(low), 32'd3);
        rd = bus2.rdata;
        e  = bus2.err;
        @(negedge CLK);
        chk("ack_one_cycle", 32'(bus2.ack), 32'd0);
        chk("ready_after_resp", 32'(bus2.ready), 32'd1);
        chk("rdata_held", bus2.rdata, rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          acks;
        int          lat;

        RST = 1'b1;
        bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = '0; bus2.wdata = '0; bus2.be = '0;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0; bus0.be = '0;

        #2;
        chk("rst_ready", 32'(bus2.ready), 32'd0);
        chk("rst_ack", 32'(bus2.ack), 32'd0);
        chk("rst_rdata", bus2.rdata, 32'd0);
        chk("rst_err", 32'(bus2.err), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("ready_after_rst", 32'(bus2.ready), 32'd1);

        // Store then load, WAIT_CYCLES=2
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e);
        chk("store10_err", 32'(e), 32'd0);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, e);
        chk("load10_rdata", rd, 32'hDEADBEEF);
        chk("load10_err", 32'(e), 32'd0);

        // Byte enables
        xfer(1'b1, 32'h20, 32'h11223344, 4'hF, rd, e);
        xfer(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, e);
        chk("be_store_oldword", rd, 32'h11223344);
        xfer(1'b0, 32'h20, 32'h0, 4'hF, rd, e);
        chk("be_load", rd, 32'h11BB33DD);
        xfer(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, e);
        chk("be0_store_oldword", rd, 32'h11BB33DD);
        xfer(1'b0, 32'h20, 32'h0, 4'h0, rd, e);
        chk("be0_nowrite", rd, 32'h11BB33DD);

        // Back-to-back loads, WAIT_CYCLES=0, req held high
        acks = 0;
        @(negedge CLK);
        bus0.req  = 1'b1;
        bus0.we   = 1'b0;
        bus0.addr = 32'h0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge CLK);
            chk($sformatf("w0_ready_%0d", i), 32'(bus0.ready), 32'((i % 2) == 0));
            chk($sformatf("w0_ack_%0d", i), 32'(bus0.ack), 32'((i % 2) == 1));
            if (bus0.ack === 1'b1) acks++;
        end
        bus0.req = 1'b0;
        chk("w0_ack_count", 32'(acks), 32'd4);

        // Reset during WAIT of a store
        xfer(1'b1, 32'h40, 32'h0, 4'hF, rd, e);
        @(negedge CLK);
        bus2.req   = 1'b1;
        bus2.we    = 1'b1;
        bus2.addr  = 32'h40;
        bus2.wdata = 32'h12345678;
        bus2.be    = 4'hF;
        @(negedge CLK);
        bus2.req = 1'b0;
        RST = 1'b1;
        #1;
        chk("midrst_ready", 32'(bus2.ready), 32'd0);
        chk("midrst_ack", 32'(bus2.ack), 32'd0);
        @(negedge CLK);
        chk("midrst_ready_hold", 32'(bus2.ready), 32'd0);
        RST = 1'b0;
        #1;
        chk("postrst_ready", 32'(bus2.ready), 32'd1);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (bus2.ack === 1'b1) acks++;
        end
        chk("postrst_no_ack", 32'(acks), 32'd0);
        xfer(1'b0, 32'h40, 32'h0, 4'h0, rd, e);
        chk("postrst_load40", rd, 32'h00000000);

        // Inputs change during WAIT: response uses latched load of 0x10
        xfer(1'b1, 32'h50, 32'hCAFEF00D, 4'hF, rd, e);
        @(negedge CLK);
        bus2.req  = 1'b1;
        bus2.we   = 1'b0;
        bus2.addr = 32'h10;
        @(negedge CLK);
        bus2.req   = 1'b0;
        bus2.we    = 1'b1;
        bus2.addr  = 32'h50;
        bus2.wdata = 32'h0;
        bus2.be    = 4'hF;
        lat = 1;
        while (bus2.ack !== 1'b1 && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        chk("chg_latency", 32'(lat), 32'd3);
        chk("chg_rdata", bus2.rdata, 32'hDEADBEEF);
        xfer(1'b0, 32'h50, 32'h0, 4'h0, rd, e);
        chk("chg_word50", rd, 32'hCAFEF00D);

        // Error checking
        xfer(1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd, e);
`ifdef DMEM_ERR_EN
        xfer(1'b0, 32'h13, 32'h0, 4'h0, rd, e);
        chk("err_misalign_err", 32'(e), 32'd1);
        chk("err_misalign_rdata", rd, 32'd0);
        xfer(1'b1, 32'(1024 * 4), 32'hFFFFFFFF, 4'hF, rd, e);
        chk("err_range_err", 32'(e), 32'd1);
        chk("err_range_rdata", rd, 32'd0);
        xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, e);
        chk("err_word0_unchanged", rd, 32'h0BADF00D);
        chk("err_ok_err", 32'(e), 32'd0);
`else
        xfer(1'b0, 32'h13, 32'h0, 4'h0, rd, e);
        chk("noerr_misalign_rdata", rd, 32'hDEADBEEF);
        chk("noerr_misalign_err", 32'(e), 32'd0);
        xfer(1'b0, 32'(1024 * 4), 32'h0, 4'h0, rd, e);
        chk("noerr_wrap_rdata", rd, 32'h0BADF00D);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
